// File: rtl/stv_nest_counter.sv
// Nested multi-level counter: level 0 advances on en, each outer level advances on the wrap of the level inside it.
// Optional STV_NEST_COUNTER_TOTAL_EN adds a saturating count of level-0 advances on total.
module stv_nest_counter #(
    parameter int               WIDTH    = 8,
    parameter int               LEVELS   = 3,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      en,
    input  logic                      down,
    input  logic                      oneshot,
    input  logic [LEVELS*WIDTH-1:0]   step,
    input  logic [LEVELS*WIDTH-1:0]   max,
    input  logic [LEVELS*WIDTH-1:0]   min,
    output logic [LEVELS*WIDTH-1:0]   count,
    output logic [LEVELS-1:0]         wrap,
    output logic                      busy,
    output logic                      done,
    output logic [LEVELS*WIDTH-1:0]   total,
    output logic [1:0]                fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt      [LEVELS];
    logic [WIDTH-1:0] cnt_next [LEVELS];
    logic             adv0;

    assign adv0      = (state == RUN) && en && !clear && !start;
    assign fsm_state = state;

    // The advance chain is carried in a local variable so wrap never feeds back into itself.
    always_comb begin
        logic             carry;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   lim;
        carry    = adv0;
        wrap     = '0;
        cnt_next = cnt;
        for (int i = 0; i < LEVELS; i++) begin
            s   = step[i*WIDTH +: WIDTH];
            s   = (s == '0) ? WIDTH'(1) : s;
            lo  = min[i*WIDTH +: WIDTH];
            hi  = max[i*WIDTH +: WIDTH];
            sum = {1'b0, cnt[i]} + {1'b0, s};
            lim = {1'b0, lo} + {1'b0, s};
            if (carry) begin
                if (down) begin
                    wrap[i]     = ({1'b0, cnt[i]} < lim);
                    cnt_next[i] = wrap[i] ? hi : (cnt[i] - s);
                end else begin
                    wrap[i]     = (sum > {1'b0, hi});
                    cnt_next[i] = wrap[i] ? lo : sum[WIDTH-1:0];
                end
            end
            carry = carry & wrap[i];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < LEVELS; i++) cnt[i] <= INIT_VAL;
        end else if (clear) begin
            for (int i = 0; i < LEVELS; i++) cnt[i] <= INIT_VAL;
        end else if (start) begin
            for (int i = 0; i < LEVELS; i++)
                cnt[i] <= down ? max[i*WIDTH +: WIDTH] : min[i*WIDTH +: WIDTH];
        end else begin
            for (int i = 0; i < LEVELS; i++) cnt[i] <= cnt_next[i];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (state == RUN && wrap[LEVELS-1] && oneshot) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < LEVELS; i++) count[i*WIDTH +: WIDTH] = cnt[i];
    end

`ifdef STV_NEST_COUNTER_TOTAL_EN
    logic [LEVELS*WIDTH-1:0] total_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            total_q <= '0;
        end else if (clear || start) begin
            total_q <= '0;
        end else if (adv0 && (total_q != '1)) begin
            total_q <= total_q + 1'b1;
        end
    end

    assign total = total_q;
`else
    assign total = '0;
`endif

endmodule

// File: tb/tb_stv_nest_counter.sv
// Bench for stv_nest_counter: reference model feeding an expected queue, directed cases and random traffic.
module tb_stv_nest_counter;

    localparam int         W    = 4;
    localparam int         L    = 2;
    localparam logic [3:0] INIT = 4'd3;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           clear = 1'b0, start = 1'b0, en = 1'b0, down = 1'b0, oneshot = 1'b0;
    logic [L*W-1:0] step = '0, max_v = '0, min_v = '0;
    logic [L*W-1:0] count, total;
    logic [L-1:0]   wrap;
    logic           busy, done;
    logic [1:0]     fsm_state;

    logic           t_clear = 1'b0, t_start = 1'b0, t_en = 1'b0;
    logic [1:0]     t_count, t_total, t_fsm_state;
    logic [0:0]     t_wrap;
    logic           t_busy, t_done;

    always #5 clk = ~clk;

    stv_nest_counter #(.WIDTH(W), .LEVELS(L), .INIT_VAL(INIT)) dut (
        .clk(clk), .arst_n(arst_n), .clear(clear), .start(start), .en(en),
        .down(down), .oneshot(oneshot), .step(step), .max(max_v), .min(min_v),
        .count(count), .wrap(wrap), .busy(busy), .done(done), .total(total),
        .fsm_state(fsm_state)
    );

    stv_nest_counter #(.WIDTH(2), .LEVELS(1), .INIT_VAL(2'd0)) dut_tot (
        .clk(clk), .arst_n(arst_n), .clear(t_clear), .start(t_start), .en(t_en),
        .down(1'b0), .oneshot(1'b0), .step(2'd1), .max(2'd3), .min(2'd0),
        .count(t_count), .wrap(t_wrap), .busy(t_busy), .done(t_done), .total(t_total),
        .fsm_state(t_fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int           m_cnt [L];
    int           m_state;
    int           m_total;
    logic [L-1:0] m_wrap;
    logic [L-1:0] last_wrap;
    logic [17:0]  exp_q [$];

    function automatic int fld(input logic [L*W-1:0] v, input int i);
        return int'(v[i*W +: W]);
    endfunction

    function automatic logic [7:0] pack_cnt();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < L; i++) r[i*W +: W] = 4'(m_cnt[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < L; i++) m_cnt[i] = int'(INIT);
        m_state = 0;
        m_total = 0;
    endtask

    // One clock: drive at negedge, check combinational wrap before the edge, check state after it.
    task automatic cycle(input logic st, input logic cl, input logic e);
        logic        adv, adv0, w;
        int          s, lo, hi;
        logic [17:0] exp, got;
        logic [7:0]  exp_total;
        @(negedge clk);
        start = st;
        clear = cl;
        en    = e;
        adv   = (m_state == 1) && e && !cl && !st;
        adv0  = adv;
        m_wrap = '0;
        for (int i = 0; i < L; i++) begin
            s  = fld(step, i);
            if (s == 0) s = 1;
            lo = fld(min_v, i);
            hi = fld(max_v, i);
            w  = 1'b0;
            if (adv) begin
                if (down) begin
                    w = (m_cnt[i] < lo + s);
                    m_cnt[i] = w ? hi : m_cnt[i] - s;
                end else begin
                    w = (m_cnt[i] + s > hi);
                    m_cnt[i] = w ? lo : m_cnt[i] + s;
                end
            end
            m_wrap[i] = w;
            adv = adv && w;
        end
        if (cl) begin
            m_state = 0;
            m_total = 0;
            for (int i = 0; i < L; i++) m_cnt[i] = int'(INIT);
        end else if (st) begin
            m_state = 1;
            m_total = 0;
            for (int i = 0; i < L; i++) m_cnt[i] = down ? fld(max_v, i) : fld(min_v, i);
        end else begin
            if (adv0 && m_total < 255) m_total++;
            if (m_state == 1 && m_wrap[L-1] && oneshot) m_state = 2;
        end
`ifdef STV_NEST_COUNTER_TOTAL_EN
        exp_total = 8'(m_total);
`else
        exp_total = 8'd0;
`endif
        exp_q.push_back({m_state == 1, m_state == 2, pack_cnt(), exp_total});
        #1;
        last_wrap = wrap;
        check("wrap", {30'd0, wrap}, {30'd0, m_wrap});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = {busy, done, count, total};
        check("busy",  {31'd0, got[17]},   {31'd0, exp[17]});
        check("done",  {31'd0, got[16]},   {31'd0, exp[16]});
        check("count", {24'd0, got[15:8]}, {24'd0, exp[15:8]});
        check("total", {24'd0, got[7:0]},  {24'd0, exp[7:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp32 [4];
        logic [3:0] exp33 [3];
        logic [1:0] exp_tot [5];
        logic [1:0] exp_tcnt [5];
        model_reset();

        // Reset state
        #12;
        check("rst_count", {24'd0, count}, 32'h33);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_wrap",  {30'd0, wrap},  32'd0);
        check("rst_total", {24'd0, total}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Two levels 0..2 step 1, oneshot: wraps at 3,6,9 and done after the 9th advance
        min_v = 8'h00; max_v = 8'h22; step = 8'h11; down = 1'b0; oneshot = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("nest_w0", {31'd0, last_wrap[0]}, {31'd0, (k % 3) == 0});
            check("nest_w1", {31'd0, last_wrap[1]}, {31'd0, k == 9});
        end
        check("nest_count", {24'd0, count}, 32'h00);
        check("nest_done",  {31'd0, done},  32'd1);
        check("nest_busy",  {31'd0, busy},  32'd0);
        cycle(1'b0, 1'b0, 1'b1);

        // Level 0 1..10 step 4 up
        exp32 = '{4'd1, 4'd5, 4'd9, 4'd1};
        min_v = 8'h01; max_v = 8'hFA; step = 8'h14; oneshot = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        check("up_start", {28'd0, count[3:0]}, {28'd0, exp32[0]});
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("up_count", {28'd0, count[3:0]}, {28'd0, exp32[k]});
            check("up_wrap",  {31'd0, last_wrap[0]}, {31'd0, k == 3});
        end

        // Level 0 down 7..2 step 3
        exp33 = '{4'd7, 4'd4, 4'd7};
        min_v = 8'h02; max_v = 8'hF7; step = 8'h13; down = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        check("dn_start", {28'd0, count[3:0]}, {28'd0, exp33[0]});
        for (int k = 1; k <= 2; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("dn_count", {28'd0, count[3:0]}, {28'd0, exp33[k]});
            check("dn_wrap",  {31'd0, last_wrap[0]}, {31'd0, k == 2});
        end

        // start and clear together while running: clear wins
        cycle(1'b1, 1'b1, 1'b0);
        check("clr_count", {24'd0, count}, 32'h33);
        check("clr_busy",  {31'd0, busy},  32'd0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("clr_hold", {24'd0, count}, 32'h33);

        // Asynchronous reset in the middle of a run with en held high
        down = 1'b0; min_v = 8'h00; max_v = 8'h55; step = 8'h11; oneshot = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check("ar_count", {24'd0, count}, 32'h33);
        check("ar_done",  {31'd0, done},  32'd0);
        check("ar_busy",  {31'd0, busy},  32'd0);
        check("ar_wrap",  {30'd0, wrap},  32'd0);
        @(posedge clk);
        #1;
        check("ar_hold", {24'd0, count}, 32'h33);
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);

        // Random traffic, including mid-run changes of direction, step and bounds
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                down    = 1'($urandom_range(0, 1));
                oneshot = 1'($urandom_range(0, 1));
                step    = 8'($urandom_range(0, 255)) & 8'h33;
                min_v   = 8'($urandom_range(0, 255));
                max_v   = 8'($urandom_range(0, 255));
            end
            cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 3) != 0));
        end

        // Single-level 2-bit instance: total saturation
        exp_tot  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_tcnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        @(negedge clk);
        t_start = 1'b1;
        @(posedge clk);
        #1;
        check("tot_start", {30'd0, t_total}, 32'd0);
        @(negedge clk);
        t_start = 1'b0;
        t_en    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("tot_count", {30'd0, t_count}, {30'd0, exp_tcnt[k]});
`ifdef STV_NEST_COUNTER_TOTAL_EN
            check("tot_total", {30'd0, t_total}, {30'd0, exp_tot[k]});
`else
            check("tot_total", {30'd0, t_total}, 32'd0);
`endif
        end
        @(negedge clk);
        t_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stv_nest_counter.md
STV_NEST_COUNTER -- requirements
Module: stv_nest_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each level's counter (>=1).
REQ-002 SHALL have parameter LEVELS, default 3, number of nested counter levels (>=1); level 0 is innermost.
REQ-003 SHALL have parameter INIT_VAL, default 0, reset/clear value of every level.
REQ-004 SHALL have a single clock and an asynchronous active-low reset.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 arst_n  input  1  asynchronous active-low reset.
REQ-007 clear  input  1  synchronous return to IDLE, all counts to INIT_VAL.
REQ-008 start  input  1  load start values, enter RUN.
REQ-009 en  input  1  advance level 0 this cycle (RUN only).
REQ-010 down  input  1  0 = count up, 1 = count down (all levels).
REQ-011 oneshot  input  1  1 = stop in DONE after outermost wrap; 0 = run continuously.
REQ-012 step  input  LEVELS*WIDTH  per-level step, level i in bits [i*WIDTH +: WIDTH]; 0 treated as 1.
REQ-013 max, min  input  LEVELS*WIDTH each  per-level runtime bounds, same packing.
REQ-014 count  output  LEVELS*WIDTH  current per-level counts, same packing.
REQ-015 wrap  output  LEVELS  combinational per-level wrap strobe.
REQ-016 busy  output  1  state == RUN.
REQ-017 done  output  1  state == DONE.
REQ-018 total  output  LEVELS*WIDTH  enabled-advance count (see Configuration).

Function
REQ-019 FSM states IDLE, RUN, DONE; clear (highest priority) -> IDLE; else start -> RUN from any state; RUN -> DONE when wrap[LEVELS-1] and oneshot; DONE held until start or clear.
REQ-020 On start, every level SHALL load min (down=0) or max (down=1) next cycle; start in RUN restarts identically.
REQ-021 Level 0 advances when state == RUN and en and not clear/start; level i>0 advances when level i-1 advances and wrap[i-1].
REQ-022 Up: wrap[i] = advance[i] and (count[i] + step[i] > max[i]), computed in WIDTH+1 bits; on wrap count[i] <- min[i], else count[i] + step[i].
REQ-023 Down: wrap[i] = advance[i] and (count[i] < min[i] + step[i]), WIDTH+1 bits; on wrap count[i] <- max[i], else count[i] - step[i].
REQ-024 Counts outside [min,max] SHALL follow REQ-022/023 unchanged (above-max counting up wraps on the next advance).
REQ-025 wrap SHALL be 0 in IDLE and DONE and whenever en=0; counts hold when not advancing.
REQ-026 Changing down, step, min or max mid-run SHALL take effect on the next advance without restart.

Reset
REQ-027 arst_n low SHALL immediately force state IDLE, every count INIT_VAL, total 0; outputs busy=0, done=0, wrap=0.
REQ-028 Reset asserted mid-RUN SHALL abort without further wrap or done pulses; restart requires start.

Configuration
REQ-029 With STV_NEST_COUNTER_TOTAL_EN defined, total SHALL clear on start/clear/reset and increment by 1 per level-0 advance, saturating at all ones.
REQ-030 Without STV_NEST_COUNTER_TOTAL_EN, total SHALL be constant 0 and no total register SHALL exist.

Verification
REQ-031 LEVELS=2 WIDTH=4, min=0 max=2 step=1 both, up, oneshot=1: start then 9 en cycles -> wrap[0] on advances 3,6,9; wrap[1] on advance 9; count={0,0}; done=1 and busy=0 the next cycle.
REQ-032 Level 0 min=1 max=10 step=4 up -> count 1,5,9,1; wrap[0] on third advance (9+4=13>10).
REQ-033 down=1, level 0 min=2 max=7 step=3 -> count 7,4,7; wrap[0] on second advance (4<2+3).
REQ-034 start and clear same cycle while RUN -> IDLE, counts INIT_VAL, busy=0; en pulses then ignored.
REQ-035 arst_n low mid-RUN, en held 1 -> immediate counts INIT_VAL, done=0; after release stays IDLE with no wrap until start.
REQ-036 TOTAL_EN defined, WIDTH=2 LEVELS=1, oneshot=0, 5 en cycles -> total 1,2,3,3,3 (saturated); undefined -> total 0 throughout.
